fifo_ser_drain: RTL and testbench

Read-side drain and parallel-to-serial converter for the P_S_FIFO path. It pops words from the synchronous FIFO's read port and shifts each word out one bit per accepted beat on a valid/ready serial interface. It also marks the first and last bit of every word. It sits between the FIFO read port and the serial line driver, and is the only agent that asserts the FIFO's read enable.

---
 rtl/fifo_ser_drain_pkg.sv | 13 +
 rtl/fifo_ser_drain_if.sv | 40 ++++
 rtl/fifo_ser_drain.sv | 109 ++++++++++
 tb/tb_fifo_ser_drain.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_drain_pkg.sv
// Shared types and defaults for the P_S_FIFO read-side drain.
// DATA_WIDTH default is shared with the FIFO instance so both ends agree.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT
    } ser_state_t;

    localparam int SER_DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_ser_drain_if.sv
// FIFO read port plus valid/ready serial port, seen from the drain (master)
// and from the FIFO / line-driver side (slave).
interface fifo_ser_drain_if
    import fifo_ser_pkg::*;
#(
    parameter int DATA_WIDTH = SER_DATA_WIDTH
);

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  ser_ready;
    logic                  ser_valid;
    logic                  ser_data;
    logic                  ser_first;
    logic                  ser_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  ser_ready,
        output fifo_rd_en,
        output ser_valid,
        output ser_data,
        output ser_first,
        output ser_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output ser_ready,
        input  fifo_rd_en,
        input  ser_valid,
        input  ser_data,
        input  ser_first,
        input  ser_last
    );

endinterface

// File: rtl/fifo_ser_drain.sv
// Pops words from a synchronous FIFO and shifts them out one bit per accepted
// beat, flagging the first and last bit of each word.
module fifo_ser_drain
    import fifo_ser_pkg::*;
#(
    parameter int DATA_WIDTH = SER_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_ser_drain_if.master bus,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    ser_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    logic in_shift;
    logic at_first;
    logic at_last;
    logic beat;
    logic rd_en;
    logic out_bit;

    // Moves the next bit to the output end, zero filling behind it.
    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[DATA_WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[DATA_WIDTH-1:1]};
        end
    endfunction

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[DATA_WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    always_comb begin
        in_shift = (state_q == SHIFT);
        at_first = in_shift && (bit_cnt_q == '0);
        at_last  = in_shift && (bit_cnt_q == LAST_CNT);
        beat     = in_shift && bus.ser_ready;
        out_bit  = in_shift && head_bit(shreg_q);
        // The next pop overlaps the final accepted beat so words run back to back.
        rd_en    = !bus.fifo_empty &&
                   ((state_q == IDLE) || (at_last && bus.ser_ready));
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rd_en) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d   = SHIFT;
                shreg_d   = bus.fifo_dout;
                bit_cnt_d = '0;
            end
            SHIFT: begin
                if (beat) begin
                    if (!at_last) begin
                        shreg_d   = shift_word(shreg_q);
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (!bus.fifo_empty) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.ser_valid  = in_shift;
    assign bus.ser_data   = out_bit;
    assign bus.ser_first  = at_first;
    assign bus.ser_last   = at_last;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_ser_drain.sv
// Directed bench for fifo_ser_drain: one MSB-first and one LSB-first instance,
// each fed by a small registered-read FIFO model that flushes on rst_n.
module tb_fifo_ser_drain;
    import fifo_ser_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy_a;
    logic busy_b;

    int vectors     = 0;
    int miscompares = 0;

    fifo_ser_drain_if #(.DATA_WIDTH(8)) bus_a ();
    fifo_ser_drain_if #(.DATA_WIDTH(8)) bus_b ();

    fifo_ser_drain #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a),
        .busy  (busy_a)
    );

    fifo_ser_drain #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b),
        .busy  (busy_b)
    );

    always #5 clk = ~clk;

    // FIFO models: pushes come from the stimulus, pops from the DUT read enable.
    logic [7:0] mem_a [0:15];
    logic [3:0] wr_a    = 4'd0;
    logic [3:0] rd_a    = 4'd0;
    logic       under_a = 1'b0;
    logic [7:0] mem_b [0:15];
    logic [3:0] wr_b    = 4'd0;
    logic [3:0] rd_b    = 4'd0;
    logic       under_b = 1'b0;

    assign bus_a.fifo_empty = (wr_a == rd_a);
    assign bus_b.fifo_empty = (wr_b == rd_b);

    initial begin
        bus_a.fifo_dout = 8'h00;
        bus_b.fifo_dout = 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a <= wr_a;
        end else if (bus_a.fifo_rd_en) begin
            if (bus_a.fifo_empty) begin
                under_a <= 1'b1;
            end else begin
                bus_a.fifo_dout <= mem_a[rd_a];
                rd_a            <= rd_a + 4'd1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_b <= wr_b;
        end else if (bus_b.fifo_rd_en) begin
            if (bus_b.fifo_empty) begin
                under_b <= 1'b1;
            end else begin
                bus_b.fifo_dout <= mem_b[rd_b];
                rd_b            <= rd_b + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        mem_a[wr_a] = w;
        wr_a        = wr_a + 4'd1;
    endtask

    task automatic push_b(input logic [7:0] w);
        mem_b[wr_b] = w;
        wr_b        = wr_b + 4'd1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_vld"},  {31'd0, bus_a.ser_valid},  32'd0);
        chk({tag, "_busy"}, {31'd0, busy_a},           32'd0);
        chk({tag, "_rd"},   {31'd0, bus_a.fifo_rd_en}, 32'd0);
    endtask

    // Expects an MSB-first word already in SHIFT; optional stall of stall_n beats at bit index stall_at.
    task automatic send_a(input string tag, input logic [7:0] w, input int stall_at,
                          input int stall_n, input logic last_rd);
        logic exp_bit;
        for (int i = 0; i < 8; i++) begin
            exp_bit = w[7-i];
            if (stall_n > 0 && i == stall_at) begin
                bus_a.ser_ready = 1'b0;
                #1;
                for (int k = 0; k < stall_n; k++) begin
                    chk({tag, "_hold_vld"},   {31'd0, bus_a.ser_valid},  32'd1);
                    chk({tag, "_hold_data"},  {31'd0, bus_a.ser_data},   {31'd0, exp_bit});
                    chk({tag, "_hold_first"}, {31'd0, bus_a.ser_first},  32'd0);
                    chk({tag, "_hold_last"},  {31'd0, bus_a.ser_last},   32'd0);
                    chk({tag, "_hold_rd"},    {31'd0, bus_a.fifo_rd_en}, 32'd0);
                    next_cyc();
                end
                bus_a.ser_ready = 1'b1;
                #1;
            end
            chk({tag, "_vld"},   {31'd0, bus_a.ser_valid}, 32'd1);
            chk({tag, "_data"},  {31'd0, bus_a.ser_data},  {31'd0, exp_bit});
            chk({tag, "_first"}, {31'd0, bus_a.ser_first}, {31'd0, (i == 0)});
            chk({tag, "_last"},  {31'd0, bus_a.ser_last},  {31'd0, (i == 7)});
            chk({tag, "_rd"},    {31'd0, bus_a.fifo_rd_en},
                {31'd0, ((i == 7) ? last_rd : 1'b0)});
            next_cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [7:0] wb;
        bus_a.ser_ready = 1'b0;
        bus_b.ser_ready = 1'b1;
        #1 rst_n = 1'b0;
        next_cyc();
        chk("rst_vld",   {31'd0, bus_a.ser_valid},  32'd0);
        chk("rst_data",  {31'd0, bus_a.ser_data},   32'd0);
        chk("rst_first", {31'd0, bus_a.ser_first},  32'd0);
        chk("rst_last",  {31'd0, bus_a.ser_last},   32'd0);
        chk("rst_busy",  {31'd0, busy_a},           32'd0);
        chk("rst_rd",    {31'd0, bus_a.fifo_rd_en}, 32'd0);
        chk("rst_vld_b", {31'd0, bus_b.ser_valid},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 0xA5: pop, gap, then 8 bits.
        @(negedge clk);
        push_a(8'hA5);
        bus_a.ser_ready = 1'b1;
        #2;
        chk("one_rd",      {31'd0, bus_a.fifo_rd_en}, 32'd1);
        chk("one_vld0",    {31'd0, bus_a.ser_valid},  32'd0);
        next_cyc();
        chk("one_wait_rd", {31'd0, bus_a.fifo_rd_en}, 32'd0);
        chk("one_wait_vld",{31'd0, bus_a.ser_valid},  32'd0);
        chk("one_wait_bsy",{31'd0, busy_a},           32'd1);
        next_cyc();
        send_a("one", 8'hA5, 0, 0, 1'b0);
        chk_idle_a("one_end");

        // Back-to-back 0x3C then 0xC3 with one gap cycle.
        @(negedge clk);
        push_a(8'h3C);
        push_a(8'hC3);
        #2;
        chk("b2b_rd", {31'd0, bus_a.fifo_rd_en}, 32'd1);
        next_cyc();
        next_cyc();
        send_a("b2b_w0", 8'h3C, 0, 0, 1'b1);
        chk("b2b_gap_vld",  {31'd0, bus_a.ser_valid},  32'd0);
        chk("b2b_gap_busy", {31'd0, busy_a},           32'd1);
        chk("b2b_gap_rd",   {31'd0, bus_a.fifo_rd_en}, 32'd0);
        next_cyc();
        send_a("b2b_w1", 8'hC3, 0, 0, 1'b0);
        chk_idle_a("b2b_end");

        // Backpressure on 0xF0: ready low for 3 cycles at bit 3.
        @(negedge clk);
        push_a(8'hF0);
        #2;
        chk("bp_rd", {31'd0, bus_a.fifo_rd_en}, 32'd1);
        next_cyc();
        next_cyc();
        send_a("bp", 8'hF0, 2, 3, 1'b0);
        chk_idle_a("bp_end");

        // Empty FIFO for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            next_cyc();
            chk_idle_a("empty");
        end
        chk("no_underflow_a", {31'd0, under_a}, 32'd0);

        // LSB-first instance: 0x01 goes out as 1 then seven 0s.
        @(negedge clk);
        push_b(8'h01);
        #2;
        chk("lsb_rd", {31'd0, bus_b.fifo_rd_en}, 32'd1);
        next_cyc();
        chk("lsb_wait_vld", {31'd0, bus_b.ser_valid}, 32'd0);
        next_cyc();
        wb = 8'h01;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_vld",   {31'd0, bus_b.ser_valid}, 32'd1);
            chk("lsb_data",  {31'd0, bus_b.ser_data},  {31'd0, wb[i]});
            chk("lsb_first", {31'd0, bus_b.ser_first}, {31'd0, (i == 0)});
            chk("lsb_last",  {31'd0, bus_b.ser_last},  {31'd0, (i == 7)});
            next_cyc();
        end
        chk("lsb_end_busy",   {31'd0, busy_b},  32'd0);
        chk("no_underflow_b", {31'd0, under_b}, 32'd0);

        // Reset mid-word at bit 4 of 0x55 with 0xAA still queued.
        @(negedge clk);
        push_a(8'h55);
        push_a(8'hAA);
        #2;
        chk("mid_rd", {31'd0, bus_a.fifo_rd_en}, 32'd1);
        next_cyc();
        next_cyc();
        wb = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk("mid_data", {31'd0, bus_a.ser_data}, {31'd0, wb[7-i]});
            next_cyc();
        end
        chk("mid_b4_vld",  {31'd0, bus_a.ser_valid}, 32'd1);
        chk("mid_b4_data", {31'd0, bus_a.ser_data},  32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",   {31'd0, bus_a.ser_valid},  32'd0);
        chk("mid_rst_data",  {31'd0, bus_a.ser_data},   32'd0);
        chk("mid_rst_first", {31'd0, bus_a.ser_first},  32'd0);
        chk("mid_rst_last",  {31'd0, bus_a.ser_last},   32'd0);
        chk("mid_rst_busy",  {31'd0, busy_a},           32'd0);
        chk("mid_rst_rd",    {31'd0, bus_a.fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_a(8'h96);
        #2;
        chk("post_rd", {31'd0, bus_a.fifo_rd_en}, 32'd1);
        next_cyc();
        chk("post_wait_vld", {31'd0, bus_a.ser_valid}, 32'd0);
        next_cyc();
        send_a("post", 8'h96, 0, 0, 1'b0);
        chk_idle_a("post_end");
        chk("no_underflow_a2", {31'd0, under_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
